// File: rtl/ttl_pkg.sv
// Shared constants for the 74x169-style counter slices and the cascade built from them.
package ttl_pkg;

    // Width of one 74x169 slice.
    localparam int SLICE_WIDTH = 4;

    // Active-low control levels, used for load, ent, enp and rco.
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

endpackage

// File: rtl/ttl_pc_cascade_if.sv
// Control and data bundle of the cascaded program counter.
interface ttl_pc_cascade_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic             ud;
    logic             ent;
    logic             enp;
    logic [WIDTH-1:0] d;
    logic             clr_wrap;
    logic             rco;
    logic [WIDTH-1:0] q;
    logic             wrap;

    // Sequencer side: drives the controls and observes the count.
    modport master (
        output load, ud, ent, enp, d, clr_wrap,
        input  rco, q, wrap
    );

    // Counter side.
    modport slave (
        input  load, ud, ent, enp, d, clr_wrap,
        output rco, q, wrap
    );
endinterface

// File: rtl/ttl74x169.sv
// One 4-bit synchronous up/down counter slice with 74x169 control semantics,
// plus an asynchronous clear used by the cascade's reset path.
module ttl74x169
    import ttl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   ud,
    input  logic                   ent,
    input  logic                   enp,
    input  logic [SLICE_WIDTH-1:0] d,
    output logic [SLICE_WIDTH-1:0] q,
    output logic                   rco
);

    logic terminal;

    // Terminal count depends on direction: all-ones counting up, zero counting down.
    always_comb begin
        terminal = ud ? (q == '1) : (q == '0);
        rco      = (ent == ASSERT_L && terminal) ? ASSERT_L : DEASSERT_L;
    end

    // Load has priority; counting needs both enables asserted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load == ASSERT_L) begin
            q <= d;
        end else if (enp == ASSERT_L && ent == ASSERT_L) begin
            q <= ud ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/ttl_pc_cascade.sv
// WIDTH-bit program counter built from cascaded 74x169 slices, with a sticky
// wrap flag raised whenever the count rolls over in either direction.
module ttl_pc_cascade
    import ttl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    ttl_pc_cascade_if.slave   bus
);

    localparam int SLICES = WIDTH / SLICE_WIDTH;

    // carry_l[k] is the active-low ent of slice k; carry_l[SLICES] is the top rco.
    logic [SLICES:0]  carry_l;
    logic [WIDTH-1:0] count;
    logic             wrap_set;
    logic             wrap_r;

    assign carry_l[0] = bus.ent;

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        ttl74x169 u_slice (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (bus.load),
            .ud      (bus.ud),
            .ent     (carry_l[k]),
            .enp     (bus.enp),
            .d       (bus.d[k*SLICE_WIDTH +: SLICE_WIDTH]),
            .q       (count[k*SLICE_WIDTH +: SLICE_WIDTH]),
            .rco     (carry_l[k+1])
        );
    end

    assign bus.q    = count;
    assign bus.rco  = carry_l[SLICES];
    assign bus.wrap = wrap_r;

    // A roll-over happens only on a real count edge with the top carry asserted;
    // loads of boundary values never qualify.
    assign wrap_set = (bus.load == DEASSERT_L) && (bus.enp == ASSERT_L) &&
                      (bus.ent == ASSERT_L) && (carry_l[SLICES] == ASSERT_L);

    // Sticky wrap flag; a set on the same edge as a clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_r <= 1'b0;
        end else if (wrap_set) begin
            wrap_r <= 1'b1;
        end else if (bus.clr_wrap) begin
            wrap_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ttl_pc_cascade.sv
// Self-checking bench for ttl_pc_cascade: directed scenarios followed by
// randomized control sequences against a plain-arithmetic reference model.
module tb_ttl_pc_cascade;

    localparam int         WIDTH = 16;
    localparam logic [15:0] ONES = 16'hFFFF;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ttl_pc_cascade_if #(.WIDTH(WIDTH)) bus ();

    ttl_pc_cascade #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: counter value and sticky flag.
    logic [15:0] q_m;
    logic        wrap_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Carry-out is asserted (low) when enabled at the terminal value for the direction.
    function automatic logic rco_ref();
        logic at_end;
        at_end = bus.ud ? (q_m == ONES) : (q_m == 16'h0000);
        return (bus.ent == 1'b0 && at_end) ? 1'b0 : 1'b1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(bus.q),    32'(q_m));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(wrap_m));
        check({tag, ".rco"},  32'(bus.rco),  32'(rco_ref()));
    endtask

    task automatic drive(input logic ld, input logic u, input logic et, input logic ep,
                         input logic [15:0] dd, input logic clr);
        bus.load     = ld;
        bus.ud       = u;
        bus.ent      = et;
        bus.enp      = ep;
        bus.d        = dd;
        bus.clr_wrap = clr;
        #1;
        check({"rco_comb"}, 32'(bus.rco), 32'(rco_ref()));
    endtask

    task automatic tick(input string tag);
        logic counting;
        logic rolls;
        @(posedge clock);
        if (reset_n) begin
            counting = bus.load && !bus.enp && !bus.ent;
            rolls    = counting && (bus.ud ? (q_m == ONES) : (q_m == 16'h0000));
            if (!bus.load)
                q_m = bus.d;
            else if (counting)
                q_m = bus.ud ? q_m + 16'd1 : q_m - 16'd1;
            if (rolls)
                wrap_m = 1'b1;
            else if (bus.clr_wrap)
                wrap_m = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        q_m     = 16'h0000;
        wrap_m  = 1'b0;
        #1;
        check_all(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.load = 1'b1; bus.ud = 1'b1; bus.ent = 1'b1; bus.enp = 1'b1;
        bus.d = 16'h0000; bus.clr_wrap = 1'b0;
        q_m = 16'h0000; wrap_m = 1'b0;

        // Reset held: edges ignored even with a load pending.
        #2;
        check_all("reset");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b0);
        tick("reset_hold");
        tick("reset_hold2");
        #2 reset_n = 1'b1;

        // Run, then reset mid-count.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
        tick("load_1234");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("count_a");
        tick("count_b");
        async_reset("mid_reset");

        // Load after reset.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h12FD, 1'b0);
        tick("load_12fd");

        // Nibble carry.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h00FE, 1'b0);
        tick("load_00fe");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("nib_00ff");
        tick("nib_0100");

        // Up wrap.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0);
        tick("load_fffe");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("up_ffff");
        tick("up_wrap");

        // Clear, then down wrap and enable gating.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
        tick("clr_only");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0);
        tick("load_0001");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("dn_0000");
        tick("dn_wrap");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) tick("enp_hold");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        tick("ent_hold");

        // Clear, boundary load must not set wrap, then set/clear collision.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
        tick("clr2");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        tick("load_ffff_nowrap");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        tick("collide");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
        tick("clr_after");

        // Load priority over an enabled count at the terminal value.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        tick("load_prio");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("load_prio0");

        // Randomized controls with boundary-biased load data.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] dv;
            case ($urandom_range(0, 4))
                0:       dv = 16'hFFFF;
                1:       dv = 16'h0000;
                2:       dv = 16'hFFFE;
                3:       dv = 16'h0001;
                default: dv = 16'($urandom);
            endcase
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  dv, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 49) == 0)
                async_reset("rand_reset");
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl_pc_cascade.md
Name: ttl_pc_cascade

Overview:
- Multi-slice synchronous up/down program counter built by cascading 4-bit ttl74x169 slices through their active-low ripple-carry chain.
- Sits directly downstream of the single 74x169 model. It consumes each slice's rco as the next slice's ent, and presents a WIDTH-bit counter with 74x169 control semantics to the CPU sequencer.
- Adds a sticky wrap flag so the sequencer can detect program-counter roll-over without sampling rco every cycle.

Parameters:
- WIDTH, 16, counter width in bits; must be a multiple of 4 (one ttl74x169 per nibble).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  active-low synchronous parallel load.
- ud  input  1  count direction: 1 = up, 0 = down.
- ent  input  1  active-low carry-in to slice 0.
- enp  input  1  active-low count enable, shared by all slices.
- d  input  WIDTH  parallel load data.
- clr_wrap  input  1  active-high synchronous clear of wrap.
- rco  output  1  active-low ripple-carry out of the top slice.
- q  output  WIDTH  counter value.
- wrap  output  1  sticky flag, high after any wrap-around.

Behaviour:
- Reset (reset_n low, asynchronous): q = 0 and wrap = 0 immediately, independent of clock. While reset_n is held low, q and wrap stay 0 and clock edges are ignored.
- Priority at each rising clock edge (when not in reset):
  - load = 0: q <= d. This ignores ent, enp and ud.
  - Otherwise, if enp = 0 and ent = 0: q <= q + 1 when ud = 1, or q <= q - 1 when ud = 0, modulo 2^WIDTH.
  - Otherwise q holds.
- Cascade rule:
  - Slice k updates only if enp = 0 and its ent_k = 0, where ent_0 = ent and ent_k = rco_(k-1).
  - Net effect is exactly the WIDTH-bit modular add/subtract above. No partial carries, and no extra cycle of latency.
- rco is combinational (no register stage). rco = 0 iff ent = 0 AND (ud = 1 and q = all-ones, OR ud = 0 and q = 0). Otherwise rco = 1.
  - rco does not depend on enp or load.
  - rco changes in the same cycle as q, ud or ent.
- wrap:
  - Set at an edge where load = 1, enp = 0, ent = 0 and rco = 0, i.e. the count crosses all-ones->0 or 0->all-ones.
  - Cleared at an edge where clr_wrap = 1.
  - If set and clear occur at the same edge, set wins.
  - A load that writes all-ones or 0 does not set wrap.
- Latency: q reflects load/count one clock after the edge that samples the controls. wrap follows the same one-clock timing.
- Direction change between cycles takes effect on the next edge with no penalty cycle.
- Reset asserted mid-count forces q = 0 and wrap = 0 at once. After reset_n deasserts, the next edge applies the normal priority rules.

Decomposition:
- Shared package (ttl_pkg):
  - SLICE_WIDTH = 4.
  - Named active-low level constants ASSERT_L = 0 and DEASSERT_L = 1, used for load, ent, enp and rco.
- Sub-module: reuse ttl74x169 as the natural slice, instantiated WIDTH/4 times in a generate loop with the rco->ent chain.
- The top level adds only the wrap register and the reset forcing. The reset path is an asynchronous clear applied to the slices' q (the slices gain an optional reset_n input defaulting inactive).

Test Plan:
- Reset then load: reset_n pulse low mid-run -> q = 0x0000, wrap = 0 immediately. Then load = 0, d = 0x12FD -> q = 0x12FD next edge, rco = 1.
- Nibble carry: q = 0x00FE, ud = 1, ent = enp = 0 -> 0x00FF, then 0x0100. rco stays 1 throughout.
- Up wrap: q = 0xFFFE, ud = 1, count -> 0xFFFF with rco = 0. Next edge -> 0x0000, wrap = 1, rco = 1.
- Down wrap and enable gating:
  - From q = 0x0001, ud = 0 -> 0x0000 with rco = 0, then 0xFFFF and wrap = 1.
  - Then enp = 1 for 3 edges -> q holds at 0xFFFF.
  - Then ent = 1 -> q holds and rco = 1.
- Wrap clear collision: clr_wrap = 1 on the same edge as a 0xFFFF->0x0000 count -> wrap stays 1. clr_wrap = 1 alone on the next edge -> wrap = 0.
- Load priority: load = 0, ent = enp = 0, ud = 1, d = 0xFFFF -> q = 0xFFFF, wrap unchanged, no count.
